// File: rtl/iq_accumulator.sv
// Readout-window I/Q accumulator: after a trigger, discards skip_len valid samples,
// then sums win_len valid I/Q samples and presents the pair with a one-cycle strobe.
module iq_accumulator #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trigger,
    input  logic [15:0]             skip_len,
    input  logic [15:0]             win_len,
    input  logic                    s_valid,
    input  logic [SAMPLE_W-1:0]     s_i,
    input  logic [SAMPLE_W-1:0]     s_q,
    output logic [2*ACC_W-1:0]      accumulated_out,
    output logic                    stb_start,
    output logic                    busy,
    output logic                    trig_overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        skip_q, skip_d;
    logic [15:0]        win_q, win_d;
    logic [ACC_W-1:0]   sumi_q, sumi_d;
    logic [ACC_W-1:0]   sumq_q, sumq_d;
    logic [2*ACC_W-1:0] out_q, out_d;
    logic               stb_q, stb_d;
    logic               busy_q;
    logic               ovr_q, ovr_d;

    logic [16:0]        cnt_inc;
    logic [ACC_W-1:0]   ext_i, ext_q;
    logic [ACC_W-1:0]   sumi_nxt, sumq_nxt;

    assign ext_i    = {{(ACC_W-SAMPLE_W){s_i[SAMPLE_W-1]}}, s_i};
    assign ext_q    = {{(ACC_W-SAMPLE_W){s_q[SAMPLE_W-1]}}, s_q};
    assign sumi_nxt = sumi_q + ext_i;
    assign sumq_nxt = sumq_q + ext_q;
    // 17-bit increment so a 65535-long window compares without wrapping
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        win_d   = win_q;
        sumi_d  = sumi_q;
        sumq_d  = sumq_q;
        out_d   = out_q;
        stb_d   = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger && (win_len != 16'd0)) begin
                    skip_d  = skip_len;
                    win_d   = win_len;
                    sumi_d  = '0;
                    sumq_d  = '0;
                    cnt_d   = '0;
                    state_d = (skip_len != 16'd0) ? ST_SKIP : ST_ACCUM;
                end
            end
            ST_SKIP: begin
                if (trigger) ovr_d = 1'b1;
                if (s_valid) begin
                    if (cnt_inc == {1'b0, skip_q}) begin
                        cnt_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_inc[15:0];
                    end
                end
            end
            ST_ACCUM: begin
                if (trigger) ovr_d = 1'b1;
                if (s_valid) begin
                    sumi_d = sumi_nxt;
                    sumq_d = sumq_nxt;
                    cnt_d  = cnt_inc[15:0];
                    if (cnt_inc == {1'b0, win_q}) begin
                        out_d   = {sumq_nxt, sumi_nxt};
                        stb_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            skip_q  <= '0;
            win_q   <= '0;
            sumi_q  <= '0;
            sumq_q  <= '0;
            out_q   <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            win_q   <= win_d;
            sumi_q  <= sumi_d;
            sumq_q  <= sumq_d;
            out_q   <= out_d;
            stb_q   <= stb_d;
            busy_q  <= (state_d != ST_IDLE);
            ovr_q   <= ovr_d;
        end
    end

    assign accumulated_out = out_q;
    assign stb_start       = stb_q;
    assign busy            = busy_q;
    assign trig_overrun    = ovr_q;

endmodule

// File: tb/tb_iq_accumulator.sv
// Bench for iq_accumulator: directed windows with literal results, then random
// traffic, all outputs compared every cycle against a sample-index model.
module tb_iq_accumulator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               trigger = 1'b0;
    logic [15:0]        skip_len = '0;
    logic [15:0]        win_len = '0;
    logic               s_valid = 1'b0;
    logic signed [15:0] s_i = '0;
    logic signed [15:0] s_q = '0;
    logic [63:0]        accumulated_out;
    logic               stb_start;
    logic               busy;
    logic               trig_overrun;

    int n_pass = 0;
    int n_total = 0;

    iq_accumulator dut (
        .clk(clk), .rst(rst), .trigger(trigger), .skip_len(skip_len),
        .win_len(win_len), .s_valid(s_valid), .s_i(s_i), .s_q(s_q),
        .accumulated_out(accumulated_out), .stb_start(stb_start),
        .busy(busy), .trig_overrun(trig_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a window is "valid sample index n since trigger"; indices skip+1..skip+win are summed.
    bit          m_busy, m_stb, m_ovr;
    int          m_skip, m_win, m_n;
    longint      m_si, m_sq;
    logic [63:0] m_out;

    initial begin
        m_busy = 0; m_stb = 0; m_ovr = 0; m_out = '0;
        m_skip = 0; m_win = 0; m_n = 0; m_si = 0; m_sq = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_stb = 0; m_ovr = 0; m_out = '0; m_si = 0; m_sq = 0; m_n = 0;
            end else begin
                m_stb = 0;
                if (!m_busy) begin
                    if (trigger && win_len != 0) begin
                        m_busy = 1; m_skip = int'(skip_len); m_win = int'(win_len);
                        m_n = 0; m_si = 0; m_sq = 0;
                    end
                end else begin
                    if (trigger) m_ovr = 1;
                    if (s_valid) begin
                        m_n++;
                        if (m_n > m_skip) begin
                            m_si += longint'(s_i);
                            m_sq += longint'(s_q);
                        end
                        if (m_n == m_skip + m_win) begin
                            m_out = {m_sq[31:0], m_si[31:0]};
                            m_stb = 1;
                            m_busy = 0;
                        end
                    end
                end
            end
            #1;
            chk("stb_start", {63'd0, stb_start}, {63'd0, m_stb});
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("trig_overrun", {63'd0, trig_overrun}, {63'd0, m_ovr});
            chk("accumulated_out", accumulated_out, m_out);
        end
    end

    task automatic step(input bit t, input bit v, input int i, input int q);
        @(negedge clk);
        trigger = t; s_valid = v; s_i = 16'(i); s_q = 16'(q);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [63:0] exp_out);
        after_edge();
        chk({name, "_stb"}, {63'd0, stb_start}, 64'd1);
        chk({name, "_out"}, accumulated_out, exp_out);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("reset_out", accumulated_out, 64'd0);
        chk("reset_flags", {61'd0, stb_start, busy, trig_overrun}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Constant samples, no skip
        skip_len = 0; win_len = 4;
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 100, -50);
        lit("const4", 64'hFFFFFF38_00000190);

        // Skip two of five ramp samples
        skip_len = 2; win_len = 3;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 1, k, 0);
        lit("skip2", 64'h00000000_0000000C);

        // Gapped valid
        skip_len = 0; win_len = 3;
        step(1, 0, 0, 0);
        step(0, 1, 7, 0); step(0, 0, 7, 0); step(0, 0, 7, 0);
        step(0, 1, 7, 0); step(0, 0, 7, 0); step(0, 1, 7, 0);
        lit("gaps", 64'h00000000_00000015);

        // Overrun: retrigger mid-window, with length changes that must not matter
        step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        skip_len = 5; win_len = 9;
        step(1, 1, 2, 1);
        step(0, 1, 3, 1);
        lit("overrun", 64'h00000003_00000006);
        chk("overrun_flag", {63'd0, trig_overrun}, 64'd1);
        // Trigger in the strobe cycle is accepted
        skip_len = 0; win_len = 2;
        step(1, 0, 0, 0);
        after_edge();
        chk("retrig_busy", {63'd0, busy}, 64'd1);
        step(0, 1, 10, -3); step(0, 1, 20, -4);
        lit("retrig", 64'hFFFFFFF9_0000001E);

        // Reset mid-ACCUM
        win_len = 4;
        step(1, 0, 0, 0);
        step(0, 1, 9, 9); step(0, 1, 9, 9);
        @(negedge clk);
        rst = 1'b1; trigger = 1'b1; s_valid = 1'b1;
        after_edge();
        chk("rst_out", accumulated_out, 64'd0);
        chk("rst_flags", {61'd0, stb_start, busy, trig_overrun}, 64'd0);
        @(negedge clk);
        rst = 1'b0; trigger = 1'b0; s_valid = 1'b0;
        win_len = 2;
        step(1, 0, 0, 0);
        step(0, 1, 5, -1); step(0, 1, 6, -1);
        lit("post_rst", 64'hFFFFFFFE_0000000B);

        // Zero-length window ignored
        win_len = 0;
        step(1, 1, 1, 1);
        after_edge();
        chk("zero_win_busy", {63'd0, busy}, 64'd0);

        // Full-scale longest window
        skip_len = 0; win_len = 16'hFFFF;
        step(1, 0, 0, 0);
        for (int k = 0; k < 65535; k++) step(0, 1, -32768, 32767);
        lit("maxwin", 64'h7FFE8001_80008000);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) == 0);
            trigger  = ($urandom_range(0, 9) == 0);
            skip_len = 16'($urandom_range(0, 5));
            win_len  = 16'($urandom_range(0, 8));
            s_valid  = ($urandom_range(0, 2) != 0);
            s_i      = 16'($urandom);
            s_q      = 16'($urandom);
        end
        @(negedge clk);
        trigger = 0; s_valid = 0; rst = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
